ooo_core_top: RTL and testbench
===============================

Name:
ooo_core_top

Overview:
- Top-level of a compact single-issue RV32I integer core with register renaming: fetch → skid buffer → rename/dispatch → execute → writeback → in-order commit through a ROB.
- Only clk and rst are external. Program is preloaded by the bench into an internal instruction memory through a hierarchical path.
- Architectural state is read by looking up the map table, then reading the physical register file.

Parameters:
- T, logic [31:0], data word type (XLEN = $bits(T)).
- IMEM_DEPTH, 512, instruction words; the PC is log2(IMEM_DEPTH) = 9 bits.
- NUM_PREGS, 128, physical registers; tags are 7 bits.
- ROB_DEPTH, 16, ROB entries; ROB index is 4 bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Debug-visible internals (exact names, bench reads them hierarchically):
  - fetch_to_cache_pc [8:0]
  - skid_to_dispatch_valid
  - rob head_ptr [3:0] and count [4:0]
  - commit_valid, commit_tag [3:0]
  - map_table[0:31] of 7 bits
  - PRF registers[0:127] of T
  - imem[0:511] of 32 bits
- Reset values:
  - PC = 0; skid buffer empty; ROB empty (head = tail = count = 0); commit_valid = 0; commit_tag = 0.
  - map_table[i] = i; registers[] all 0.
  - Free list FIFO holds p32..p127 (96 entries).
  - imem is NOT cleared by reset.
- Fetch:
  - imem is read synchronously from word address PC; the instruction is valid one cycle later.
  - PC increments by 1 each cycle unless the skid buffer is full. It wraps 511→0 with no other effect.
  - Reset mid-run clears the pipeline and returns PC to 0.
- Skid buffer:
  - 2 entries; absorbs the one in-flight fetch when dispatch stalls.
  - skid_to_dispatch_valid = 1 when an instruction is presented to dispatch.
- Rename/dispatch:
  - Dispatch fires when skid_to_dispatch_valid, the ROB is not full (count < 16), and either the free list is not empty or rd is x0 / not written.
  - Sources: read map_table[rs1], map_table[rs2].
  - If writing rd ≠ 0: pop a new physical register, record the old mapping in the ROB entry, update map_table[rd].
  - x0 always maps to p0; registers[0] is never written.
- Supported ops:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI, AUIPC. The AUIPC byte PC is {PC, 2'b00} zero-extended.
  - All other opcodes execute as no-write: they occupy a ROB entry and commit normally. No branches, so PC flow is never redirected.
- Execute:
  - One cycle after dispatch.
  - Operands come from the PRF with bypass from the writeback stage, so back-to-back dependent ops need no stall.
  - Shift amount is the low 5 bits. Arithmetic wraps modulo 2^32.
- Writeback: the next cycle writes registers[pd] and marks the ROB entry done.
- Commit:
  - When ROB count > 0 and the head entry is done: commit_valid = 1 for that cycle; commit_tag = head_ptr.
  - The old physical register is pushed to the free list (unless it is p0); head_ptr increments (wrap 15→0); count decrements.
  - At most one commit per cycle.
  - A simultaneous dispatch and commit leaves count unchanged.
- Throughput: 1 instruction/cycle steady state.

Optional Feature:
- Macro OOO_COMMIT_TRACE_EN.
- Defined: every commit prints $display "COMMIT t=<time> rob=<tag> rd=x<n> pd=p<m> val=<hex>".
- Undefined: no display output; functional behaviour identical.

Test Plan:
- imem all 0x00000013, reset 10 cycles → all x1..x31 = 0; fetch_to_cache_pc counts up and wraps 0x1FF→0x000; commit_valid pulses continuously.
- ADDI x1,x0,5; ADD x2,x1,x1 (back-to-back) → x1 = 5, x2 = 10 (bypass path).
- ADDI x3,x0,-1; SRLI x4,x3,28; SRAI x5,x3,4 → x3 = 0xFFFFFFFF, x4 = 0xF, x5 = 0xFFFFFFFF.
- LUI x6,0x12345; ADDI x6,x6,0x678 → x6 = 0x12345678; SUB x7,x0,x6 → x7 = 0xEDCBA988.
- ADDI x0,x0,7 → x0 reads 0, map_table[0] stays 0; 200 consecutive writes to x1 → free list never empties, last value wins.
- Assert rst mid-program → next cycle PC = 0, ROB count = 0, map_table identity, registers all 0.

Source files
------------

// File: rtl/ooo_core_top.sv
// ooo_core_top: single-issue RV32I integer core with register renaming and in-order ROB commit.
// Define OOO_COMMIT_TRACE_EN to print one COMMIT line per retired instruction.
module ooo_core_top #(
  parameter type T          = logic [31:0],
  parameter int  IMEM_DEPTH = 512,
  parameter int  NUM_PREGS  = 128,
  parameter int  ROB_DEPTH  = 16
) (
  input logic clk,
  input logic rst
);
  localparam int PW = $clog2(IMEM_DEPTH);
  localparam int TW = $clog2(NUM_PREGS);
  localparam int RW = $clog2(ROB_DEPTH);
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17;

  logic [31:0]   imem      [0:IMEM_DEPTH-1];
  logic [TW-1:0] map_table [0:31];
  T              registers [0:NUM_PREGS-1];

  logic [PW-1:0] pc_q, pc_d, f_pc_q, fetch_to_cache_pc;
  logic          f_valid_q, f_valid_d, fetch_en;
  logic [31:0]   f_instr_q;

  logic [31:0]   sk_instr_q [2];
  logic [PW-1:0] sk_pc_q [2];
  logic          sk_rd_q, sk_rd_d, sk_wr_q, sk_wr_d, skid_to_dispatch_valid;
  logic [1:0]    sk_cnt_q, sk_cnt_d;

  logic [31:0]   d_instr;
  logic [PW-1:0] d_pc;
  logic [4:0]    d_rd;
  logic [TW-1:0] d_pd;
  logic          d_writes, dispatch;

  logic [TW-1:0] fl_q [NUM_PREGS];
  logic [TW-1:0] fl_head_q, fl_head_d, fl_tail_q, fl_tail_d;
  logic [TW:0]   fl_cnt_q, fl_cnt_d;
  logic          fl_push;

  logic          rob_done_q [ROB_DEPTH];
  logic          rob_wr_q   [ROB_DEPTH];
  logic [TW-1:0] rob_pd_q   [ROB_DEPTH];
  logic [TW-1:0] rob_old_q  [ROB_DEPTH];
  logic [RW-1:0] head_ptr_q, head_ptr_d, tail_q, tail_d, head_ptr, commit_tag;
  logic [RW:0]   count_q, count_d, count;
  logic          commit_valid;

  logic          ex_valid_q, ex_wr_q;
  logic [6:0]    ex_opc_q;
  logic [19:0]   ex_hi_q;
  logic [PW-1:0] ex_pc_q;
  logic [TW-1:0] ex_ps1_q, ex_ps2_q, ex_pd_q;
  logic [RW-1:0] ex_rob_q;
  logic [2:0]    ex_f3;
  T              ex_a, ex_b, ex_imm, ex_op2, ex_res;

  logic          wb_valid_q, wb_wr_q;
  logic [TW-1:0] wb_pd_q;
  logic [RW-1:0] wb_rob_q;
  T              wb_val_q;

  assign fetch_to_cache_pc = pc_q;
  assign head_ptr          = head_ptr_q;
  assign commit_tag        = head_ptr_q;
  assign count             = count_q;

  always_comb begin
    d_instr  = sk_instr_q[sk_rd_q];
    d_pc     = sk_pc_q[sk_rd_q];
    d_rd     = d_instr[11:7];
    d_writes = (d_instr[6:0] inside {OP_R, OP_I, OP_LUI, OP_AUIPC}) && d_rd != 5'd0;
    d_pd     = d_writes ? fl_q[fl_head_q] : '0;
    skid_to_dispatch_valid = sk_cnt_q != 2'd0;
    dispatch = skid_to_dispatch_valid && count_q < (RW+1)'(ROB_DEPTH) &&
               (fl_cnt_q != '0 || !d_writes);
    commit_valid = count_q != '0 && rob_done_q[head_ptr_q];
    fl_push      = commit_valid && rob_wr_q[head_ptr_q] && rob_old_q[head_ptr_q] != '0;
    // Fetch only if the skid buffer can still take this fetch when it lands next cycle.
    sk_cnt_d   = sk_cnt_q + {1'b0, f_valid_q} - {1'b0, dispatch};
    fetch_en   = sk_cnt_d < 2'd2;
    pc_d       = fetch_en ? pc_q + PW'(1) : pc_q;
    f_valid_d  = fetch_en;
    sk_rd_d    = sk_rd_q ^ dispatch;
    sk_wr_d    = sk_wr_q ^ f_valid_q;
    fl_head_d  = fl_head_q + TW'(dispatch && d_writes);
    fl_tail_d  = fl_tail_q + TW'(fl_push);
    fl_cnt_d   = fl_cnt_q + (TW+1)'(fl_push) - (TW+1)'(dispatch && d_writes);
    head_ptr_d = head_ptr_q + RW'(commit_valid);
    tail_d     = tail_q + RW'(dispatch);
    count_d    = count_q + (RW+1)'(dispatch) - (RW+1)'(commit_valid);
  end

  // Execute: operands from the PRF, with the writeback result forwarded.
  always_comb begin
    ex_f3  = ex_hi_q[2:0];
    ex_imm = {{20{ex_hi_q[19]}}, ex_hi_q[19:8]};
    ex_a   = (wb_valid_q && wb_wr_q && wb_pd_q == ex_ps1_q) ? wb_val_q : registers[ex_ps1_q];
    ex_b   = (wb_valid_q && wb_wr_q && wb_pd_q == ex_ps2_q) ? wb_val_q : registers[ex_ps2_q];
    ex_op2 = (ex_opc_q == OP_R) ? ex_b : ex_imm;
    ex_res = '0;
    case (ex_f3)
      3'd0: ex_res = (ex_opc_q == OP_R && ex_hi_q[18]) ? ex_a - ex_op2 : ex_a + ex_op2;
      3'd1: ex_res = ex_a << ex_op2[4:0];
      3'd2: ex_res = {31'd0, $signed(ex_a) < $signed(ex_op2)};
      3'd3: ex_res = {31'd0, ex_a < ex_op2};
      3'd4: ex_res = ex_a ^ ex_op2;
      3'd5: begin
        if (ex_hi_q[18]) ex_res = $signed(ex_a) >>> ex_op2[4:0];
        else             ex_res = ex_a >> ex_op2[4:0];
      end
      3'd6: ex_res = ex_a | ex_op2;
      default: ex_res = ex_a & ex_op2;
    endcase
    if (ex_opc_q == OP_LUI)        ex_res = {ex_hi_q, 12'd0};
    else if (ex_opc_q == OP_AUIPC) ex_res = {ex_hi_q, 12'd0} + 32'({ex_pc_q, 2'b00});
  end

  always_ff @(posedge clk) begin
    if (fetch_en) begin
      f_instr_q <= imem[pc_q];
      f_pc_q    <= pc_q;
    end
    if (f_valid_q) begin
      sk_instr_q[sk_wr_q] <= f_instr_q;
      sk_pc_q[sk_wr_q]    <= f_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      f_valid_q  <= 1'b0;
      sk_rd_q    <= 1'b0;
      sk_wr_q    <= 1'b0;
      sk_cnt_q   <= '0;
      fl_head_q  <= '0;
      fl_tail_q  <= TW'(NUM_PREGS - 32);
      fl_cnt_q   <= (TW+1)'(NUM_PREGS - 32);
      head_ptr_q <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
      wb_valid_q <= 1'b0;
      for (int i = 0; i < 32; i++) map_table[i] <= TW'(i);
      // Slots past the tail are don't-care; p32.. fill the first NUM_PREGS-32.
      for (int i = 0; i < NUM_PREGS; i++) begin
        registers[i] <= '0;
        fl_q[i]      <= TW'(i + 32);
      end
    end else begin
      pc_q       <= pc_d;
      f_valid_q  <= f_valid_d;
      sk_rd_q    <= sk_rd_d;
      sk_wr_q    <= sk_wr_d;
      sk_cnt_q   <= sk_cnt_d;
      fl_head_q  <= fl_head_d;
      fl_tail_q  <= fl_tail_d;
      fl_cnt_q   <= fl_cnt_d;
      head_ptr_q <= head_ptr_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (dispatch) begin
        rob_done_q[tail_q] <= 1'b0;
        rob_wr_q[tail_q]   <= d_writes;
        rob_pd_q[tail_q]   <= d_pd;
        rob_old_q[tail_q]  <= map_table[d_rd];
        if (d_writes) map_table[d_rd] <= d_pd;
      end
      if (fl_push) fl_q[fl_tail_q] <= rob_old_q[head_ptr_q];
      ex_valid_q <= dispatch;
      ex_wr_q    <= d_writes;
      ex_opc_q   <= d_instr[6:0];
      ex_hi_q    <= d_instr[31:12];
      ex_pc_q    <= d_pc;
      ex_ps1_q   <= map_table[d_instr[19:15]];
      ex_ps2_q   <= map_table[d_instr[24:20]];
      ex_pd_q    <= d_pd;
      ex_rob_q   <= tail_q;
      wb_valid_q <= ex_valid_q;
      wb_wr_q    <= ex_wr_q;
      wb_pd_q    <= ex_pd_q;
      wb_rob_q   <= ex_rob_q;
      wb_val_q   <= ex_res;
      if (wb_valid_q) begin
        rob_done_q[wb_rob_q] <= 1'b1;
        if (wb_wr_q) registers[wb_pd_q] <= wb_val_q;
      end
    end
  end

`ifdef OOO_COMMIT_TRACE_EN
  logic [4:0] rob_rd_q [ROB_DEPTH];
  always_ff @(posedge clk) begin
    if (!rst && dispatch) rob_rd_q[tail_q] <= d_rd;
    if (!rst && commit_valid)
      $display("COMMIT t=%0t rob=%0d rd=x%0d pd=p%0d val=%08h", $time, commit_tag,
               rob_wr_q[head_ptr_q] ? rob_rd_q[head_ptr_q] : 5'd0, rob_pd_q[head_ptr_q],
               registers[rob_pd_q[head_ptr_q]]);
  end
`else
  // Trace disabled: commits update state silently.
`endif
endmodule

// File: tb/tb_ooo_core_top.sv
// Self-checking bench for ooo_core_top: directed programs plus random programs
// compared against an in-order architectural model of RV32I integer ops.
module tb_ooo_core_top;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ooo_core_top dut (.clk(clk), .rst(rst));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] prog [$];
  logic [31:0] mreg [32];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] arch(input int i);
    return dut.registers[dut.map_table[i]];
  endfunction

  // ISA-level ALU: funct3 selects the operation, alt selects SUB / SRA.
  function automatic logic [31:0] alu(input logic [2:0] f3, input bit alt,
                                      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: begin
        if (alt) r = $signed(x) >>> y[4:0];
        else     r = x >> y[4:0];
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic void model_step(input logic [31:0] ins, input int pc);
    logic [31:0] a, b, imm, v;
    bit wr;
    a = mreg[ins[19:15]];
    b = mreg[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    v = '0;
    wr = 1'b1;
    case (ins[6:0])
      7'h37: v = {ins[31:12], 12'h000};
      7'h17: v = {ins[31:12], 12'h000} + 32'(pc * 4);
      7'h33: v = alu(ins[14:12], ins[30], a, b);
      7'h13: v = alu(ins[14:12], ins[14:12] == 3'd5 && ins[30], a, imm);
      default: wr = 1'b0;
    endcase
    if (wr && ins[11:7] != 5'd0) mreg[ins[11:7]] = v;
  endfunction

  function automatic void model_run();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    foreach (prog[i]) model_step(prog[i], i);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] other [5];
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [11:0] imm;
    logic [6:0] f7;
    int k;
    other = '{7'h03, 7'h23, 7'h63, 7'h0F, 7'h73};
    k   = $urandom_range(0, 9);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    f7  = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if (k < 4) return enc_r((f3 == 3'd0 || f3 == 3'd5) ? f7 : 7'h00, rs2, rs1, f3, rd);
    if (k < 7) begin
      if (f3 == 3'd1)      imm = {7'h00, imm[4:0]};
      else if (f3 == 3'd5) imm = {f7, imm[4:0]};
      return enc_i(imm, rs1, f3, rd);
    end
    if (k == 7) return enc_u(20'($urandom), rd, 7'h37);
    if (k == 8) return enc_u(20'($urandom), rd, 7'h17);
    return {imm, rs1, f3, rd, other[$urandom_range(0, 4)]};
  endfunction

  task automatic start_prog(input int hold);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 512; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : NOP;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic count_commits(input int n, output int seen);
    int cyc;
    cyc = 0;
    seen = 0;
    while (seen < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (dut.commit_valid) seen++;
    end
  endtask

  task automatic test_reset();
    logic [8:0] prev_pc, exp_pc;
    logic [3:0] exp_tag;
    bit started, wrapped;
    prog.delete();
    start_prog(10);
    vectors++;
    if (dut.fetch_to_cache_pc !== 9'd0 || dut.count !== 5'd0 || dut.head_ptr !== 4'd0 ||
        dut.commit_valid !== 1'b0 || dut.commit_tag !== 4'd0 || dut.skid_to_dispatch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: pc=%0h count=%0d head=%0d cv=%b tag=%0d skid=%b, need all 0",
               dut.fetch_to_cache_pc, dut.count, dut.head_ptr, dut.commit_valid, dut.commit_tag,
               dut.skid_to_dispatch_valid);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (dut.map_table[i] !== 7'(i) || arch(i) !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_map x%0d: map=p%0d val=%h, need p%0d val=0", i, dut.map_table[i], arch(i), i);
      end
    end
    prev_pc = 9'd0; exp_tag = 4'd0; started = 1'b0; wrapped = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_pc = prev_pc + 9'd1;
      vectors++;
      if (dut.fetch_to_cache_pc !== exp_pc) begin
        miscompares++;
        $display("FAIL pc_step cyc%0d: pc=%0h, need %0h", c, dut.fetch_to_cache_pc, exp_pc);
      end
      if (prev_pc == 9'h1FF && dut.fetch_to_cache_pc == 9'h000) wrapped = 1'b1;
      prev_pc = dut.fetch_to_cache_pc;
      if (started) begin
        vectors++;
        if (dut.commit_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL commit_stream cyc%0d: commit_valid=%b, need 1", c, dut.commit_valid);
        end
      end
      if (dut.commit_valid) begin
        started = 1'b1;
        vectors++;
        if (dut.commit_tag !== exp_tag) begin
          miscompares++;
          $display("FAIL commit_tag cyc%0d: tag=%0d, need %0d", c, dut.commit_tag, exp_tag);
        end
        exp_tag++;
      end
    end
    vectors++;
    if (!wrapped || !started) begin
      miscompares++;
      $display("FAIL pc_wrap: wrapped=%b commits_seen=%b, need 1 1", wrapped, started);
    end
    for (int i = 1; i < 32; i++) begin
      vectors++;
      if (arch(i) !== 32'd0) begin
        miscompares++;
        $display("FAIL nop_regs x%0d: %h, need 0", i, arch(i));
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] exp_v [8];
    int seen;
    exp_v = '{32'd0, 32'd5, 32'd10, 32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF,
              32'h1234_5678, 32'hEDCB_A988};
    prog.delete();
    prog.push_back(enc_i(12'd5, 5'd0, 3'd0, 5'd1));
    prog.push_back(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
    prog.push_back(enc_i(12'hFFF, 5'd0, 3'd0, 5'd3));
    prog.push_back(enc_i(12'h01C, 5'd3, 3'd5, 5'd4));
    prog.push_back(enc_i(12'h404, 5'd3, 3'd5, 5'd5));
    prog.push_back(enc_u(20'h12345, 5'd6, 7'h37));
    prog.push_back(enc_i(12'h678, 5'd6, 3'd0, 5'd6));
    prog.push_back(enc_r(7'h20, 5'd6, 5'd0, 3'd0, 5'd7));
    start_prog(3);
    count_commits(prog.size(), seen);
    vectors++;
    if (seen != prog.size()) begin
      miscompares++;
      $display("FAIL directed_commits: got %0d, need %0d", seen, prog.size());
    end
    for (int i = 1; i < 8; i++) begin
      vectors++;
      if (arch(i) !== exp_v[i]) begin
        miscompares++;
        $display("FAIL directed x%0d: %h, need %h", i, arch(i), exp_v[i]);
      end
    end
  endtask

  task automatic test_x0_and_reuse();
    int seen;
    prog.delete();
    prog.push_back(enc_i(12'd7, 5'd0, 3'd0, 5'd0));
    for (int k = 1; k <= 200; k++) prog.push_back(enc_i(12'(k), 5'd0, 3'd0, 5'd1));
    start_prog(3);
    count_commits(prog.size(), seen);
    vectors++;
    if (seen != prog.size()) begin
      miscompares++;
      $display("FAIL reuse_commits: got %0d, need %0d", seen, prog.size());
    end
    vectors++;
    if (dut.map_table[0] !== 7'd0 || dut.registers[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_fixed: map=p%0d val=%h, need p0 0", dut.map_table[0], dut.registers[0]);
    end
    vectors++;
    if (arch(1) !== 32'd200) begin
      miscompares++;
      $display("FAIL last_write_x1: %h, need %h", arch(1), 32'd200);
    end
  endtask

  task automatic test_random();
    int seen;
    for (int r = 0; r < 3; r++) begin
      prog.delete();
      for (int k = 0; k < 300; k++) prog.push_back(rand_instr());
      model_run();
      start_prog(2);
      count_commits(prog.size(), seen);
      vectors++;
      if (seen != prog.size()) begin
        miscompares++;
        $display("FAIL rand%0d_commits: got %0d, need %0d", r, seen, prog.size());
      end
      for (int i = 0; i < 32; i++) begin
        vectors++;
        if (arch(i) !== mreg[i]) begin
          miscompares++;
          $display("FAIL rand%0d x%0d: %h, need %h", r, i, arch(i), mreg[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    prog.delete();
    for (int k = 0; k < 200; k++) prog.push_back(rand_instr());
    model_run();
    start_prog(2);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (dut.fetch_to_cache_pc !== 9'd0 || dut.count !== 5'd0 || dut.head_ptr !== 4'd0 ||
        dut.commit_valid !== 1'b0 || dut.skid_to_dispatch_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ctrl: pc=%0h count=%0d head=%0d cv=%b skid=%b, need all 0",
               dut.fetch_to_cache_pc, dut.count, dut.head_ptr, dut.commit_valid,
               dut.skid_to_dispatch_valid);
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (dut.map_table[i] !== 7'(i) || arch(i) !== 32'd0) begin
        miscompares++;
        $display("FAIL midrst_map x%0d: map=p%0d val=%h, need p%0d 0", i, dut.map_table[i], arch(i), i);
      end
    end
    rst = 1'b0;
    count_commits(prog.size(), seen);
    vectors++;
    if (seen != prog.size()) begin
      miscompares++;
      $display("FAIL midrst_commits: got %0d, need %0d", seen, prog.size());
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (arch(i) !== mreg[i]) begin
        miscompares++;
        $display("FAIL midrst_rerun x%0d: %h, need %h", i, arch(i), mreg[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_x0_and_reuse();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
